logic_unit_arbiter: RTL and testbench

- Shares one pipelined two-input bitwise logic datapath (e.g. nand_b_b_b, fixed latency) between two requesters.
- Round-robin arbitration with valid/ready request handshakes.
- Drives the datapath operand/op ports and tracks in-flight operations with a tagged latency pipeline.
- Returns each result to the requester that issued it; placed between request sources and one shared logic datapath instance.

---
 rtl/logic_unit_arbiter_if.sv | 56 +++++
 rtl/logic_unit_arbiter.sv | 87 ++++++++
 tb/tb_logic_unit_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_arbiter_if.sv
// Bundle of request/response handshakes and datapath connections for the
// shared logic-unit arbiter.
//
// Handshake: a request is transferred on a rising clock edge where
// reqN_valid && reqN_ready are both 1. ready is combinational from valid,
// en and the priority pointer, and is never 1 without its valid.
// Responses have no backpressure: rspN_valid is high for exactly one
// cycle, and rspN_y is 0 whenever rspN_valid is 0.
interface logic_unit_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             en;
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_y;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_y;
  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_b;
  logic [1:0]       dp_op;
  logic [WIDTH-1:0] dp_y;
  logic             busy;

  // Arbiter side
  modport slave (
    input  en,
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready, rsp0_valid, rsp0_y,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready, rsp1_valid, rsp1_y,
    output dp_a, dp_b, dp_op,
    input  dp_y,
    output busy
  );

  // Requester / datapath side
  modport master (
    output en,
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready, rsp0_valid, rsp0_y,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready, rsp1_valid, rsp1_y,
    input  dp_a, dp_b, dp_op,
    output dp_y,
    input  busy
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for one pipelined bitwise logic
// datapath. Accepted operations are registered onto dp_a/dp_b/dp_op and a
// requester tag travels alongside through a LAT+1 deep tracking pipeline so
// each dp_y result is routed back to the requester that issued it.
module logic_unit_arbiter #(
  parameter int WIDTH = 1,
  parameter int LAT   = 1
) (
  input logic                  clock,
  input logic                  reset,
  logic_unit_arbiter_if.slave  bus
);

  logic             ptr;          // index of the most recent grant
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [WIDTH-1:0] dp_a_q;
  logic [WIDTH-1:0] dp_b_q;
  logic [1:0]       dp_op_q;
  // Entry i is valid i edges after acceptance; entry LAT lines up with dp_y.
  logic [LAT:0]     trk_valid;
  logic [LAT:0]     trk_tag;
  logic             rsp_hit;

  // Grant selection: lone requester wins, on conflict the one opposite ptr
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.en) begin
      if (bus.req0_valid && (!bus.req1_valid || ptr)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign accept         = grant0 || grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Priority pointer follows the granted index; reset value lets req0 win first
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b1;
    end else if (accept) begin
      ptr <= grant1;
    end
  end

  // Operand/op registers toward the datapath hold until the next grant
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dp_a_q  <= '0;
      dp_b_q  <= '0;
      dp_op_q <= 2'd0;
    end else if (accept) begin
      dp_a_q  <= grant1 ? bus.req1_a  : bus.req0_a;
      dp_b_q  <= grant1 ? bus.req1_b  : bus.req0_b;
      dp_op_q <= grant1 ? bus.req1_op : bus.req0_op;
    end
  end

  // Tag pipeline tracking in-flight operations; reset discards them all
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trk_valid <= '0;
      trk_tag   <= '0;
    end else begin
      trk_valid <= {trk_valid[LAT-1:0], accept};
      trk_tag   <= {trk_tag[LAT-1:0], grant1};
    end
  end

  assign rsp_hit = trk_valid[LAT];

  assign bus.dp_a       = dp_a_q;
  assign bus.dp_b       = dp_b_q;
  assign bus.dp_op      = dp_op_q;
  assign bus.rsp0_valid = rsp_hit && !trk_tag[LAT];
  assign bus.rsp1_valid = rsp_hit &&  trk_tag[LAT];
  assign bus.rsp0_y     = (rsp_hit && !trk_tag[LAT]) ? bus.dp_y : '0;
  assign bus.rsp1_y     = (rsp_hit &&  trk_tag[LAT]) ? bus.dp_y : '0;
  assign bus.busy       = |trk_valid;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: one LAT=1 instance (a) and one LAT=3
// instance (b), each fed by a small registered model of the logic datapath.
module tb_logic_unit_arbiter;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  logic_unit_arbiter_if #(.WIDTH(1)) ifa ();
  logic_unit_arbiter_if #(.WIDTH(1)) ifb ();

  logic_unit_arbiter #(.WIDTH(1), .LAT(1)) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  logic_unit_arbiter #(.WIDTH(1), .LAT(3)) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // datapath models (not reset, so dp_y keeps moving through a reset)
  function automatic logic lu(input logic a, input logic b, input logic [1:0] op);
    case (op)
      2'd0:    lu = a & b;
      2'd1:    lu = a | b;
      2'd2:    lu = a ^ b;
      default: lu = ~(a & b);
    endcase
  endfunction

  logic ya;
  logic yb1, yb2, yb3;
  always @(posedge clock) begin
    ya  <= lu(ifa.dp_a, ifa.dp_b, ifa.dp_op);
    yb1 <= lu(ifb.dp_a, ifb.dp_b, ifb.dp_op);
    yb2 <= yb1;
    yb3 <= yb2;
  end
  assign ifa.dp_y = ya;
  assign ifb.dp_y = yb3;

  // driver tasks
  task automatic idle_inputs();
    ifa.en = 1'b0; ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
    ifa.req0_a = 1'b0; ifa.req0_b = 1'b0; ifa.req0_op = 2'd0;
    ifa.req1_a = 1'b0; ifa.req1_b = 1'b0; ifa.req1_op = 2'd0;
    ifb.en = 1'b0; ifb.req0_valid = 1'b0; ifb.req1_valid = 1'b0;
    ifb.req0_a = 1'b0; ifb.req0_b = 1'b0; ifb.req0_op = 2'd0;
    ifb.req1_a = 1'b0; ifb.req1_b = 1'b0; ifb.req1_op = 2'd0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    total++;
    if ({ifa.dp_a, ifa.dp_b, ifa.dp_op} !== 4'b0000) begin
      bad++; $display("FAIL reset_dp_a got=%b exp=0000", {ifa.dp_a, ifa.dp_b, ifa.dp_op});
    end
    total++;
    if ({ifa.busy, ifa.rsp0_valid, ifa.rsp1_valid, ifa.rsp0_y, ifa.rsp1_y} !== 5'b00000) begin
      bad++; $display("FAIL reset_out_a got=%b exp=00000",
                      {ifa.busy, ifa.rsp0_valid, ifa.rsp1_valid, ifa.rsp0_y, ifa.rsp1_y});
    end
    total++;
    if ({ifb.dp_a, ifb.dp_b, ifb.dp_op, ifb.busy, ifb.rsp0_valid, ifb.rsp1_valid} !== 7'b0) begin
      bad++; $display("FAIL reset_b got=%b exp=0000000",
                      {ifb.dp_a, ifb.dp_b, ifb.dp_op, ifb.busy, ifb.rsp0_valid, ifb.rsp1_valid});
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clock);
    ifa.en = 1'b1; ifa.req0_valid = 1'b1;
    ifa.req0_a = 1'b1; ifa.req0_b = 1'b1; ifa.req0_op = 2'd3;
    #1;
    total++;
    if ({ifa.req0_ready, ifa.req1_ready} !== 2'b10) begin
      bad++; $display("FAIL single_ready got=%b exp=10", {ifa.req0_ready, ifa.req1_ready});
    end
    @(posedge clock);
    #1;
    ifa.req0_valid = 1'b0;
    total++;
    if ({ifa.dp_a, ifa.dp_b, ifa.dp_op, ifa.busy, ifa.rsp0_valid} !== 6'b111110) begin
      bad++; $display("FAIL single_dp got=%b exp=111110",
                      {ifa.dp_a, ifa.dp_b, ifa.dp_op, ifa.busy, ifa.rsp0_valid});
    end
    @(posedge clock);
    #1;
    total++;
    if ({ifa.rsp0_valid, ifa.rsp0_y, ifa.rsp1_valid, ifa.busy} !== 4'b1001) begin
      bad++; $display("FAIL single_rsp got=%b exp=1001",
                      {ifa.rsp0_valid, ifa.rsp0_y, ifa.rsp1_valid, ifa.busy});
    end
    @(posedge clock);
    #1;
    total++;
    if ({ifa.rsp0_valid, ifa.rsp1_valid, ifa.busy} !== 3'b000) begin
      bad++; $display("FAIL single_idle got=%b exp=000", {ifa.rsp0_valid, ifa.rsp1_valid, ifa.busy});
    end
  endtask

  task automatic test_both_valid();
    apply_reset();
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      if (j < 4) begin
        ifa.en = 1'b1;
        ifa.req0_valid = 1'b1; ifa.req0_a = 1'b1; ifa.req0_b = 1'b0; ifa.req0_op = 2'd3;
        ifa.req1_valid = 1'b1; ifa.req1_a = 1'b1; ifa.req1_b = 1'b1; ifa.req1_op = 2'd0;
        #1;
        total++;
        if ({ifa.req0_ready, ifa.req1_ready} !== ((j % 2 == 0) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL both_grant%0d got=%b exp=%b", j,
                          {ifa.req0_ready, ifa.req1_ready}, (j % 2 == 0) ? 2'b10 : 2'b01);
        end
      end else begin
        ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
      end
      @(posedge clock);
      #1;
      if (j >= 1) begin
        // grant j-1 responds now: req0 on odd j, req1 on even j, both results 1
        total++;
        if ({ifa.rsp0_valid, ifa.rsp0_y, ifa.rsp1_valid, ifa.rsp1_y} !==
            ((j % 2 == 1) ? 4'b1100 : 4'b0011)) begin
          bad++; $display("FAIL both_rsp%0d got=%b exp=%b", j - 1,
                          {ifa.rsp0_valid, ifa.rsp0_y, ifa.rsp1_valid, ifa.rsp1_y},
                          (j % 2 == 1) ? 4'b1100 : 4'b0011);
        end
      end
    end
  endtask

  task automatic test_enable();
    // last grant was req1 with (a=1, b=1, op=0), pointer now 1
    @(negedge clock);
    ifa.en = 1'b0;
    ifa.req0_valid = 1'b1; ifa.req0_a = 1'b0; ifa.req0_b = 1'b0; ifa.req0_op = 2'd2;
    ifa.req1_valid = 1'b1; ifa.req1_a = 1'b0; ifa.req1_b = 1'b1; ifa.req1_op = 2'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({ifa.req0_ready, ifa.req1_ready} !== 2'b00) begin
        bad++; $display("FAIL en0_ready%0d got=%b exp=00", i, {ifa.req0_ready, ifa.req1_ready});
      end
      @(posedge clock);
      #1;
      total++;
      if ({ifa.dp_a, ifa.dp_b, ifa.dp_op} !== 4'b1100) begin
        bad++; $display("FAIL en0_hold%0d got=%b exp=1100", i, {ifa.dp_a, ifa.dp_b, ifa.dp_op});
      end
      @(negedge clock);
    end
    ifa.en = 1'b1;
    #1;
    total++;
    if ({ifa.req0_ready, ifa.req1_ready} !== 2'b10) begin
      bad++; $display("FAIL en1_first got=%b exp=10", {ifa.req0_ready, ifa.req1_ready});
    end
    @(posedge clock);
    #1;
    total++;
    if ({ifa.dp_a, ifa.dp_b, ifa.dp_op} !== 4'b0010) begin
      bad++; $display("FAIL en1_dp0 got=%b exp=0010", {ifa.dp_a, ifa.dp_b, ifa.dp_op});
    end
    @(negedge clock);
    #1;
    total++;
    if ({ifa.req0_ready, ifa.req1_ready} !== 2'b01) begin
      bad++; $display("FAIL en1_second got=%b exp=01", {ifa.req0_ready, ifa.req1_ready});
    end
    @(posedge clock);
    #1;
    total++;
    if ({ifa.rsp0_valid, ifa.rsp0_y, ifa.rsp1_valid, ifa.dp_a, ifa.dp_b, ifa.dp_op} !== 7'b1000101) begin
      bad++; $display("FAIL en1_rsp0 got=%b exp=1000101",
                      {ifa.rsp0_valid, ifa.rsp0_y, ifa.rsp1_valid, ifa.dp_a, ifa.dp_b, ifa.dp_op});
    end
    @(negedge clock);
    ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
    @(posedge clock);
    #1;
    total++;
    if ({ifa.rsp0_valid, ifa.rsp1_valid, ifa.rsp1_y} !== 3'b011) begin
      bad++; $display("FAIL en1_rsp1 got=%b exp=011", {ifa.rsp0_valid, ifa.rsp1_valid, ifa.rsp1_y});
    end
  endtask

  task automatic test_lat3();
    @(negedge clock);
    ifb.en = 1'b1;
    ifb.req1_valid = 1'b1; ifb.req1_a = 1'b1; ifb.req1_b = 1'b0; ifb.req1_op = 2'd1;
    #1;
    total++;
    if ({ifb.req0_ready, ifb.req1_ready} !== 2'b01) begin
      bad++; $display("FAIL lat3_ready got=%b exp=01", {ifb.req0_ready, ifb.req1_ready});
    end
    @(posedge clock);
    #1;
    total++;
    if ({ifb.busy, ifb.rsp1_valid} !== 2'b10) begin
      bad++; $display("FAIL lat3_k got=%b exp=10", {ifb.busy, ifb.rsp1_valid});
    end
    @(negedge clock);
    ifb.en = 1'b0; ifb.req1_valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clock);
      #1;
      total++;
      if ({ifb.busy, ifb.rsp1_valid, ifb.rsp1_y, ifb.rsp0_valid} !==
          ((e < 3) ? 4'b1000 : (e == 3) ? 4'b1110 : 4'b0000)) begin
        bad++; $display("FAIL lat3_k+%0d got=%b exp=%b", e,
                        {ifb.busy, ifb.rsp1_valid, ifb.rsp1_y, ifb.rsp0_valid},
                        (e < 3) ? 4'b1000 : (e == 3) ? 4'b1110 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clock);
    ifa.en = 1'b1;
    ifa.req0_valid = 1'b1; ifa.req0_a = 1'b1; ifa.req0_b = 1'b1; ifa.req0_op = 2'd1;
    @(posedge clock);
    @(negedge clock);
    ifa.req0_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({ifa.dp_a, ifa.dp_b, ifa.dp_op, ifa.busy, ifa.rsp0_valid, ifa.rsp0_y} !== 7'b0) begin
      bad++; $display("FAIL rst_async got=%b exp=0000000",
                      {ifa.dp_a, ifa.dp_b, ifa.dp_op, ifa.busy, ifa.rsp0_valid, ifa.rsp0_y});
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      total++;
      if ({ifa.rsp0_valid, ifa.rsp1_valid, ifa.busy} !== 3'b000) begin
        bad++; $display("FAIL rst_quiet%0d got=%b exp=000", i,
                        {ifa.rsp0_valid, ifa.rsp1_valid, ifa.busy});
      end
    end
  endtask

  task automatic test_op_sweep();
    logic [15:0] sweep_exp;
    logic [3:0]  idx;
    // bit {a,b,op}: a=0,b=0 -> 0001 ; 01 -> 0111 ; 10 -> 0111 ; 11 -> 1100 (op 3..0 read right to left)
    sweep_exp = 16'b0011_1110_1110_1000;
    for (int j = 0; j < 17; j++) begin
      @(negedge clock);
      if (j < 16) begin
        idx = 4'(j);
        ifa.en = 1'b1; ifa.req1_valid = 1'b0; ifa.req0_valid = 1'b1;
        ifa.req0_a = idx[3]; ifa.req0_b = idx[2]; ifa.req0_op = idx[1:0];
        #1;
        total++;
        if (ifa.req0_ready !== 1'b1) begin
          bad++; $display("FAIL sweep_ready%0d got=%b exp=1", j, ifa.req0_ready);
        end
      end else begin
        ifa.req0_valid = 1'b0;
      end
      @(posedge clock);
      #1;
      if (j >= 1) begin
        idx = 4'(j - 1);
        total++;
        if ({ifa.rsp0_valid, ifa.rsp0_y, ifa.rsp1_valid} !== {1'b1, sweep_exp[idx], 1'b0}) begin
          bad++; $display("FAIL sweep_rsp%0d got=%b exp=%b", j - 1,
                          {ifa.rsp0_valid, ifa.rsp0_y, ifa.rsp1_valid}, {1'b1, sweep_exp[idx], 1'b0});
        end
      end
    end
    @(posedge clock);
    #1;
    total++;
    if ({ifa.rsp0_valid, ifa.busy} !== 2'b00) begin
      bad++; $display("FAIL sweep_end got=%b exp=00", {ifa.rsp0_valid, ifa.busy});
    end
  endtask

  // sequence and final report
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_both_valid();
    test_enable();
    test_lat3();
    test_reset_mid_op();
    test_op_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
